// File: rtl/positron_layer_serializer_pkg.sv
// Shared posit-layer definitions: serializer FSM encoding and index sizing helper.
package posit_defines;

    typedef enum logic {
        SER_COLLECT = 1'b0,
        SER_STREAM  = 1'b1
    } serializer_state_t;

    // Ceiling log2; returns 0 for values <= 1.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/positron_layer_serializer_if.sv
// Lane-side capture bus plus the serial output stream of one positron layer.
interface positron_layer_serializer_if #(
    parameter int POSIT_WIDTH = 4,
    parameter int NB_POSITRON = 16
);
    // Handshake: a beat transfers on a rising clk edge where valid (rts) and
    // ready (rtr) are both high; once raised, valid and its payload hold
    // stable until that transfer and ready never gates whether valid rises.
    logic [NB_POSITRON-1:0]             rts_i;
    logic [NB_POSITRON-1:0]             eow_i;
    logic [NB_POSITRON*POSIT_WIDTH-1:0] posit_i;
    logic [NB_POSITRON-1:0]             rtr_o;
    logic                               rtr_i;
    logic                               rts_o;
    logic                               sow_o;
    logic                               eow_o;
    logic [POSIT_WIDTH-1:0]             posit_o;

    modport master (
        output rts_i, eow_i, posit_i, rtr_i,
        input  rtr_o, rts_o, sow_o, eow_o, posit_o
    );

    modport slave (
        input  rts_i, eow_i, posit_i, rtr_i,
        output rtr_o, rts_o, sow_o, eow_o, posit_o
    );

endinterface

// File: rtl/positron_layer_serializer.sv
// Captures one end-of-window posit per upstream positron, then replays the
// layer as a sow/eow-framed serial window, one posit per beat.
module positron_layer_serializer
    import posit_defines::*;
#(
    parameter int POSIT_WIDTH = 4,
    parameter int NB_POSITRON = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    positron_layer_serializer_if.slave bus,
    output serializer_state_t          state_dbg
);

    localparam int IDX_W = (log2(NB_POSITRON) > 1) ? log2(NB_POSITRON) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_POSITRON - 1);

    serializer_state_t        state_q, state_d;
    logic [NB_POSITRON-1:0]   flag_q, flag_d;
    logic [NB_POSITRON-1:0]   cap;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [POSIT_WIDTH-1:0]   buf_q [NB_POSITRON];
    logic                     streaming;
    logic                     last_beat;

    assign streaming = (state_q == SER_STREAM);
    assign last_beat = (idx_q == LAST_IDX);

    // A lane is only accepted while collecting and not yet captured this window.
    assign cap = streaming ? '0 : (bus.rts_i & ~flag_q);

    always_comb begin
        state_d = state_q;
        flag_d  = flag_q;
        idx_d   = idx_q;
        case (state_q)
            SER_COLLECT: begin
                flag_d = flag_q | cap;
                if (&flag_d) begin
                    state_d = SER_STREAM;
                    idx_d   = '0;
                end
            end
            SER_STREAM: begin
                if (bus.rtr_i) begin
                    if (last_beat) begin
                        flag_d  = '0;
                        idx_d   = '0;
                        state_d = SER_COLLECT;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = SER_COLLECT;
                flag_d  = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SER_COLLECT;
            flag_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            flag_q  <= flag_d;
            idx_q   <= idx_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NB_POSITRON; k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NB_POSITRON; k++) begin
                if (cap[k]) begin
                    buf_q[k] <= bus.posit_i[k*POSIT_WIDTH +: POSIT_WIDTH];
                end
            end
        end
    end

    // Outputs decode registered state only, so they cannot retract under rtr_i.
    assign bus.rtr_o   = streaming ? '0 : ~flag_q;
    assign bus.rts_o   = streaming;
    assign bus.sow_o   = streaming && (idx_q == '0);
    assign bus.eow_o   = streaming && last_beat;
    assign bus.posit_o = streaming ? buf_q[idx_q] : '0;
    assign state_dbg   = state_q;

    // Upstream positrons only present a result at the end of their window.
    assert property (@(posedge clk) disable iff (!rst_n)
        ((bus.rts_i & ~bus.eow_i) == '0));

endmodule

// File: tb/tb_positron_layer_serializer.sv
// Directed and randomized checks of the layer serializer against a window-level model.
module tb_positron_layer_serializer;
    import posit_defines::*;

    localparam int PW = 4;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    positron_layer_serializer_if #(.POSIT_WIDTH(PW), .NB_POSITRON(NB)) bus ();
    positron_layer_serializer_if #(.POSIT_WIDTH(PW), .NB_POSITRON(1))  bus1 ();
    serializer_state_t state_dbg, state_dbg1;

    assign bus.eow_i  = bus.rts_i;
    assign bus1.eow_i = bus1.rts_i;

    positron_layer_serializer #(.POSIT_WIDTH(PW), .NB_POSITRON(NB)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .state_dbg(state_dbg));

    positron_layer_serializer #(.POSIT_WIDTH(PW), .NB_POSITRON(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1), .state_dbg(state_dbg1));

    int n_cmp = 0;
    int n_err = 0;
    logic [PW-1:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.rts_i    = '0;
        bus.posit_i  = '0;
        bus.rtr_i    = 1'b1;
        bus1.rts_i   = '0;
        bus1.posit_i = '0;
        bus1.rtr_i   = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (3) tick();
        n_cmp++; if (bus.rtr_o !== 4'hF) begin n_err++; $display("FAIL reset_rtr: got %h exp f", bus.rtr_o); end
        n_cmp++; if (bus.rts_o !== 1'b0) begin n_err++; $display("FAIL reset_rts: got %b exp 0", bus.rts_o); end
        n_cmp++; if ({bus.sow_o, bus.eow_o} !== 2'b00) begin n_err++; $display("FAIL reset_sow_eow: got %b exp 00", {bus.sow_o, bus.eow_o}); end
        n_cmp++; if (bus.posit_o !== 4'h0) begin n_err++; $display("FAIL reset_posit: got %h exp 0", bus.posit_o); end
        n_cmp++; if (state_dbg !== SER_COLLECT) begin n_err++; $display("FAIL reset_state: got %0d exp %0d", state_dbg, SER_COLLECT); end
        n_cmp++; if (bus1.rtr_o !== 1'b1) begin n_err++; $display("FAIL reset_rtr1: got %b exp 1", bus1.rtr_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int beat;
        bus.rts_i   = 4'hF;
        bus.posit_i = {4'h4, 4'h3, 4'h2, 4'h1};
        exp_q = '{4'h1, 4'h2, 4'h3, 4'h4};
        tick();
        bus.rts_i = '0;
        beat = 0;
        while (exp_q.size() > 0) begin
            n_cmp++; if (bus.rts_o !== 1'b1) begin n_err++; $display("FAIL basic_rts beat %0d: got %b exp 1", beat, bus.rts_o); end
            n_cmp++; if (bus.posit_o !== exp_q[0]) begin n_err++; $display("FAIL basic_posit beat %0d: got %h exp %h", beat, bus.posit_o, exp_q[0]); end
            n_cmp++; if (bus.sow_o !== (beat == 0)) begin n_err++; $display("FAIL basic_sow beat %0d: got %b", beat, bus.sow_o); end
            n_cmp++; if (bus.eow_o !== (beat == NB-1)) begin n_err++; $display("FAIL basic_eow beat %0d: got %b", beat, bus.eow_o); end
            n_cmp++; if (bus.rtr_o !== 4'h0) begin n_err++; $display("FAIL basic_rtr beat %0d: got %h exp 0", beat, bus.rtr_o); end
            tick();
            void'(exp_q.pop_front());
            beat++;
        end
        n_cmp++; if (bus.rtr_o !== 4'hF) begin n_err++; $display("FAIL basic_after_rtr: got %h exp f", bus.rtr_o); end
        n_cmp++; if (bus.rts_o !== 1'b0) begin n_err++; $display("FAIL basic_after_rts: got %b exp 0", bus.rts_o); end
    endtask

    task automatic test_skew();
        logic [PW-1:0] d [NB];
        int beat;
        for (int k = 0; k < NB; k++) d[k] = PW'($urandom);
        bus.rts_i   = 4'b1011;
        bus.posit_i = {d[3], 4'h0, d[1], d[0]};
        tick();
        bus.rts_i = '0;
        for (int i = 1; i <= 5; i++) begin
            n_cmp++; if (bus.rtr_o !== 4'b0100) begin n_err++; $display("FAIL skew_rtr cycle %0d: got %b exp 0100", i, bus.rtr_o); end
            n_cmp++; if (bus.rts_o !== 1'b0) begin n_err++; $display("FAIL skew_rts cycle %0d: got %b exp 0", i, bus.rts_o); end
            if (i == 5) begin
                bus.rts_i   = 4'b0100;
                bus.posit_i = {4'h0, d[2], 4'h0, 4'h0};
            end
            tick();
        end
        bus.rts_i = '0;
        for (int k = 0; k < NB; k++) exp_q.push_back(d[k]);
        beat = 0;
        while (exp_q.size() > 0) begin
            n_cmp++; if (bus.rts_o !== 1'b1) begin n_err++; $display("FAIL skew_stream_rts beat %0d: got %b exp 1", beat, bus.rts_o); end
            n_cmp++; if (bus.posit_o !== exp_q[0]) begin n_err++; $display("FAIL skew_posit beat %0d: got %h exp %h", beat, bus.posit_o, exp_q[0]); end
            n_cmp++; if (bus.sow_o !== (beat == 0)) begin n_err++; $display("FAIL skew_sow beat %0d: got %b", beat, bus.sow_o); end
            tick();
            void'(exp_q.pop_front());
            beat++;
        end
    endtask

    task automatic test_backpressure();
        int beat, stall, cyc;
        bus.rts_i   = 4'hF;
        bus.posit_i = {4'h4, 4'h3, 4'h2, 4'h1};
        exp_q = '{4'h1, 4'h2, 4'h3, 4'h4};
        tick();
        bus.rts_i = '0;
        beat = 0; stall = 0; cyc = 0;
        while (exp_q.size() > 0 && cyc < 50) begin
            n_cmp++; if (bus.rts_o !== 1'b1) begin n_err++; $display("FAIL bp_rts cycle %0d: got %b exp 1", cyc, bus.rts_o); end
            n_cmp++; if (bus.posit_o !== exp_q[0]) begin n_err++; $display("FAIL bp_posit cycle %0d: got %h exp %h", cyc, bus.posit_o, exp_q[0]); end
            n_cmp++; if (bus.eow_o !== (exp_q.size() == 1)) begin n_err++; $display("FAIL bp_eow cycle %0d: got %b", cyc, bus.eow_o); end
            n_cmp++; if (bus.sow_o !== (beat == 0)) begin n_err++; $display("FAIL bp_sow cycle %0d: got %b", cyc, bus.sow_o); end
            bus.rtr_i = !(beat == 2 && stall < 3);
            if (!bus.rtr_i) stall++;
            tick();
            cyc++;
            if (bus.rtr_i) begin
                void'(exp_q.pop_front());
                beat++;
            end
        end
        bus.rtr_i = 1'b1;
        n_cmp++; if (cyc !== 7) begin n_err++; $display("FAIL bp_cycles: got %0d exp 7", cyc); end
        n_cmp++; if (bus.rtr_o !== 4'hF) begin n_err++; $display("FAIL bp_after_rtr: got %h exp f", bus.rtr_o); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int beat;
        bus.rts_i   = 4'hF;
        bus.posit_i = {4'h4, 4'h3, 4'h2, 4'h1};
        exp_q = '{4'h1, 4'h2, 4'h3, 4'h4};
        tick();
        bus.posit_i = {4'h8, 4'h7, 4'h6, 4'h5};
        for (int w = 0; w < 2; w++) begin
            beat = 0;
            while (exp_q.size() > 0) begin
                n_cmp++; if (bus.rtr_o !== 4'h0) begin n_err++; $display("FAIL b2b_rtr win %0d beat %0d: got %h exp 0", w, beat, bus.rtr_o); end
                n_cmp++; if (bus.posit_o !== exp_q[0]) begin n_err++; $display("FAIL b2b_posit win %0d beat %0d: got %h exp %h", w, beat, bus.posit_o, exp_q[0]); end
                n_cmp++; if ({bus.sow_o, bus.eow_o} !== {beat == 0, beat == NB-1}) begin n_err++; $display("FAIL b2b_frame win %0d beat %0d: got %b", w, beat, {bus.sow_o, bus.eow_o}); end
                tick();
                void'(exp_q.pop_front());
                beat++;
            end
            if (w == 0) begin
                n_cmp++; if (bus.rts_o !== 1'b0) begin n_err++; $display("FAIL b2b_gap_rts: got %b exp 0", bus.rts_o); end
                n_cmp++; if (bus.rtr_o !== 4'hF) begin n_err++; $display("FAIL b2b_gap_rtr: got %h exp f", bus.rtr_o); end
                tick();
                bus.rts_i = '0;
                exp_q = '{4'h5, 4'h6, 4'h7, 4'h8};
            end
        end
        bus.posit_i = '0;
    endtask

    task automatic test_reset_mid_stream();
        logic [PW-1:0] d [NB];
        int beat;
        bus.rts_i   = 4'hF;
        bus.posit_i = {4'hC, 4'hB, 4'hA, 4'h9};
        tick();
        bus.rts_i = '0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.rts_o !== 1'b0) begin n_err++; $display("FAIL rstmid_rts: got %b exp 0", bus.rts_o); end
        n_cmp++; if (bus.rtr_o !== 4'hF) begin n_err++; $display("FAIL rstmid_rtr: got %h exp f", bus.rtr_o); end
        n_cmp++; if (state_dbg !== SER_COLLECT) begin n_err++; $display("FAIL rstmid_state: got %0d exp %0d", state_dbg, SER_COLLECT); end
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < NB; k++) begin
            d[k] = PW'($urandom);
            bus.posit_i[k*PW +: PW] = d[k];
            exp_q.push_back(d[k]);
        end
        bus.rts_i = 4'hF;
        tick();
        bus.rts_i = '0;
        beat = 0;
        while (exp_q.size() > 0) begin
            n_cmp++; if (bus.posit_o !== exp_q[0]) begin n_err++; $display("FAIL rstmid_posit beat %0d: got %h exp %h", beat, bus.posit_o, exp_q[0]); end
            n_cmp++; if (bus.sow_o !== (beat == 0)) begin n_err++; $display("FAIL rstmid_sow beat %0d: got %b", beat, bus.sow_o); end
            tick();
            void'(exp_q.pop_front());
            beat++;
        end
    endtask

    task automatic test_single_lane();
        bus1.rts_i   = 1'b1;
        bus1.posit_i = 4'hA;
        tick();
        bus1.rts_i = 1'b0;
        n_cmp++; if (bus1.rts_o !== 1'b1) begin n_err++; $display("FAIL single_rts: got %b exp 1", bus1.rts_o); end
        n_cmp++; if ({bus1.sow_o, bus1.eow_o} !== 2'b11) begin n_err++; $display("FAIL single_frame: got %b exp 11", {bus1.sow_o, bus1.eow_o}); end
        n_cmp++; if (bus1.posit_o !== 4'hA) begin n_err++; $display("FAIL single_posit: got %h exp a", bus1.posit_o); end
        n_cmp++; if (bus1.rtr_o !== 1'b0) begin n_err++; $display("FAIL single_rtr: got %b exp 0", bus1.rtr_o); end
        tick();
        n_cmp++; if (bus1.rts_o !== 1'b0) begin n_err++; $display("FAIL single_after_rts: got %b exp 0", bus1.rts_o); end
        n_cmp++; if (bus1.rtr_o !== 1'b1) begin n_err++; $display("FAIL single_after_rtr: got %b exp 1", bus1.rtr_o); end
    endtask

    task automatic test_random();
        int arr [NB];
        logic [PW-1:0] d [NB];
        int max_arr, beat, cyc;
        logic [NB-1:0] exp_rtr;
        for (int w = 0; w < 30; w++) begin
            max_arr = 0;
            for (int k = 0; k < NB; k++) begin
                arr[k] = $urandom_range(0, 3);
                d[k]   = PW'($urandom);
                if (arr[k] > max_arr) max_arr = arr[k];
            end
            // Collect phase: a lane is expected to have been taken once its arrival cycle has passed.
            for (int c = 0; c <= max_arr; c++) begin
                exp_rtr = '1;
                for (int k = 0; k < NB; k++) if (arr[k] < c) exp_rtr[k] = 1'b0;
                n_cmp++; if (bus.rtr_o !== exp_rtr) begin n_err++; $display("FAIL rand_rtr win %0d cycle %0d: got %b exp %b", w, c, bus.rtr_o, exp_rtr); end
                n_cmp++; if (bus.rts_o !== 1'b0) begin n_err++; $display("FAIL rand_collect_rts win %0d cycle %0d: got %b exp 0", w, c, bus.rts_o); end
                for (int k = 0; k < NB; k++) begin
                    bus.rts_i[k] = (arr[k] == c);
                    bus.posit_i[k*PW +: PW] = (arr[k] == c) ? d[k] : PW'($urandom);
                end
                tick();
            end
            for (int k = 0; k < NB; k++) exp_q.push_back(d[k]);
            beat = 0; cyc = 0;
            while (exp_q.size() > 0) begin
                if (cyc > 100) begin
                    n_cmp++; n_err++;
                    $display("FAIL rand_timeout win %0d: got %0d beats exp %0d", w, beat, NB);
                    exp_q.delete();
                    break;
                end
                n_cmp++; if (bus.rts_o !== 1'b1) begin n_err++; $display("FAIL rand_rts win %0d beat %0d: got %b exp 1", w, beat, bus.rts_o); end
                n_cmp++; if (bus.posit_o !== exp_q[0]) begin n_err++; $display("FAIL rand_posit win %0d beat %0d: got %h exp %h", w, beat, bus.posit_o, exp_q[0]); end
                n_cmp++; if ({bus.sow_o, bus.eow_o} !== {beat == 0, exp_q.size() == 1}) begin n_err++; $display("FAIL rand_frame win %0d beat %0d: got %b", w, beat, {bus.sow_o, bus.eow_o}); end
                n_cmp++; if (bus.rtr_o !== 4'h0) begin n_err++; $display("FAIL rand_stream_rtr win %0d beat %0d: got %h exp 0", w, beat, bus.rtr_o); end
                bus.rtr_i   = ($urandom_range(0, 2) != 0);
                bus.rts_i   = NB'($urandom);
                bus.posit_i = (NB*PW)'($urandom);
                tick();
                cyc++;
                if (bus.rtr_i) begin
                    void'(exp_q.pop_front());
                    beat++;
                end
            end
            bus.rts_i = '0;
            bus.rtr_i = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_skew();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_stream();
        test_single_lane();
        test_random();
        drive_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
